// File: rtl/add_mux_pkg.sv
// Opcode definitions shared by the add_mux_slice ALU datapath.
package add_mux_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  // Opcodes whose result comes from the ripple adder and therefore report a carry.
  function automatic logic uses_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/add_1bit.sv
// Purely combinational full-adder slice used in the ripple chain.
module add_1bit (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_mux_slice.sv
// Registered WIDTH-bit ALU core: ripple adder of add_1bit slices plus a result selector.
// Optional macro ADD_MUX_SLICE_OVF_EN enables the overflow output and the SLT overflow correction.
module add_mux_slice
  import add_mux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  // Valid-only stream: a result is produced one cycle after every in_valid
  // beat; there is no ready, so the consumer must accept every out_valid beat.

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] res;
  logic             slt_bit;
  logic             cout_d;

  assign bin  = b ^ {WIDTH{cntrl[0]}};
  assign c[0] = (cntrl == OP_ADD) ? cin : 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    add_1bit u_slice (
      .sum  (sum[i]),
      .cout (c[i+1]),
      .a    (a[i]),
      .b    (bin[i]),
      .cin  (c[i])
    );
  end

`ifdef ADD_MUX_SLICE_OVF_EN
  logic ovf_raw;
  logic ovf_d;
  logic ovf_q;

  assign ovf_raw = c[WIDTH] ^ c[WIDTH-1];
  assign slt_bit = sum[WIDTH-1] ^ ovf_raw;
  assign ovf_d   = ((cntrl == OP_ADD) || (cntrl == OP_SUB)) ? ovf_raw : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Uncorrected sign of A-B: only meaningful when the subtraction does not overflow.
  assign slt_bit = sum[WIDTH-1];
  assign ovf     = 1'b0;
`endif

  always_comb begin
    res = '0;
    case (cntrl)
      OP_ADD,
      OP_SUB:  res = sum;
      OP_XOR:  res = a ^ b;
      OP_SLT:  res[0] = slt_bit;
      OP_MUL:  res = a & b;
      default: res = '0;
    endcase
  end

  assign cout_d = uses_carry(cntrl) ? c[WIDTH] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= res;
        cout <= cout_d;
        zero <= (res == '0);
      end
    end
  end

endmodule

// File: tb/tb_add_mux_slice.sv
// Self-checking bench for add_mux_slice at WIDTH=4 using an expected-result queue.
// Expectations follow ADD_MUX_SLICE_OVF_EN when it is defined for the build.
module tb_add_mux_slice;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 3;  // {out, cout, ovf, zero}

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       cntrl;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             out_valid;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;
  int           n_checks;
  int           n_errors;
  bit           done;

  add_mux_slice #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .cntrl     (cntrl),
    .out       (out),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent arithmetic model of the datapath at WIDTH=4.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [3:0] x,
                                          input logic [3:0] y, input logic ci);
    logic [4:0] s;
    logic [3:0] r;
    logic [3:0] ny;
    logic       co;
    logic       ov;
    r  = 4'd0;
    co = 1'b0;
    ov = 1'b0;
    ny = ~y;
    case (op)
      3'b000: begin
        s  = {1'b0, x} + {1'b0, y} + {4'd0, ci};
        r  = s[3:0];
        co = s[4];
        ov = (x[3] == y[3]) && (r[3] != x[3]);
      end
      3'b001: begin
        s  = {1'b0, x} + {1'b0, ny} + 5'd1;
        r  = s[3:0];
        co = s[4];
        ov = (x[3] != y[3]) && (r[3] != x[3]);
      end
      3'b010: r = x ^ y;
      3'b011: begin
        s  = {1'b0, x} + {1'b0, ny} + 5'd1;
        co = s[4];
`ifdef ADD_MUX_SLICE_OVF_EN
        r  = {3'd0, ($signed(x) < $signed(y))};
`else
        r  = {3'd0, s[3]};
`endif
      end
      3'b100: r = x & y;
      default: r = 4'd0;
    endcase
`ifndef ADD_MUX_SLICE_OVF_EN
    ov = 1'b0;
`endif
    return {r, co, ov, (r == 4'd0)};
  endfunction

  // driver: inputs change on the falling edge, expected result queued when it will be sampled
  task automatic drive(input logic rn, input logic vld, input logic [2:0] op,
                       input logic [3:0] x, input logic [3:0] y, input logic ci);
    @(negedge clk);
    rst_n    = rn;
    in_valid = vld;
    cntrl    = op;
    a        = x;
    b        = y;
    cin      = ci;
    if (rn && vld) exp_q.push_back(model(op, x, y, ci));
  endtask

  // scoreboard: compares registered outputs shortly after each rising edge
  initial begin
    logic [W-1:0] got;
    held = '0;
    @(negedge clk);
    while (!done) begin
      @(posedge clk);
      #1;
      if (done) break;
      got = {out, cout, ovf, zero};
      if (!rst_n) begin
        exp_q.delete();
        held = '0;
        check_eq("reset_valid", {31'd0, out_valid}, 32'd0);
      end else if (in_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("queue_underflow", 32'd0, 32'd1);
        end else begin
          held = exp_q.pop_front();
        end
        check_eq("out_valid_hi", {31'd0, out_valid}, 32'd1);
      end else begin
        check_eq("out_valid_lo", {31'd0, out_valid}, 32'd0);
      end
      check_eq("result", {25'd0, got}, {25'd0, held});
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    done     = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    cntrl    = 3'b000;

    // reset held two cycles with a valid operation presented
    drive(1'b0, 1'b1, 3'b000, 4'b0111, 4'b0001, 1'b0);
    drive(1'b0, 1'b1, 3'b000, 4'b0111, 4'b0001, 1'b0);

    // ADD
    drive(1'b1, 1'b1, 3'b000, 4'b0111, 4'b0001, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 4'b1111, 4'b0001, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 4'b0001, 4'b0001, 1'b1);
    // SUB / SLT
    drive(1'b1, 1'b1, 3'b001, 4'b0011, 4'b0101, 1'b0);
    drive(1'b1, 1'b1, 3'b011, 4'b0011, 4'b0101, 1'b0);
    drive(1'b1, 1'b1, 3'b011, 4'b0111, 4'b1000, 1'b0);
    // logic ops and reserved
    drive(1'b1, 1'b1, 3'b010, 4'b1100, 4'b1010, 1'b1);
    drive(1'b1, 1'b1, 3'b100, 4'b1100, 4'b1010, 1'b0);
    drive(1'b1, 1'b1, 3'b101, 4'b1100, 4'b1010, 1'b0);

    // hold: valid ADD giving 1000, then idle with fresh operands
    drive(1'b1, 1'b1, 3'b000, 4'b0111, 4'b0001, 1'b0);
    drive(1'b1, 1'b0, 3'b001, 4'b0010, 4'b0110, 1'b1);
    @(posedge clk);
    #2;
    check_eq("hold_out", {28'd0, out}, 32'h8);
    check_eq("hold_valid", {31'd0, out_valid}, 32'd0);

    // random stream with gaps and an occasional mid-stream reset
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    drive(1'b1, 1'b0, 3'b000, 4'd0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 4'd0, 4'd0, 1'b0);
    @(posedge clk);
    #2;
    check_eq("queue_drained", exp_q.size(), 32'd0);
    done = 1'b1;
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/add_mux_slice.md
# add_mux_slice

Registered WIDTH-bit ALU datapath built from a ripple chain of `add_1bit` full-adder slices and a per-bit `mux_5bit` result selector. It performs ADD, SUB, XOR, SLT and MUL (1-bit partial product, i.e. AND) under a 3-bit control code. It sits in the MIPS ALU as the arithmetic/logic core and feeds the writeback/flag logic. All operand and result paths are registered with a one-cycle valid pipeline.

## Interface
- `WIDTH`, default 32: operand/result width, minimum 2.
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst_n`  in  1: reset is synchronous and active-low.
- `in_valid`  in  1: operands/control valid this cycle.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `cin`  in  1: carry-in to LSB, used by ADD only.
- `cntrl`  in  3: operation code.
- `out`  out  WIDTH: registered result.
- `cout`  out  1: registered carry out of MSB.
- `ovf`  out  1: registered signed overflow.
- `zero`  out  1: registered, 1 when `out` is all zeros.
- `out_valid`  out  1: registered `in_valid`.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 MUL, 101–111 reserved.
- Adder input per bit: `bin[i] = b[i] ^ cntrl[0]`, so SUB and SLT invert B.
- LSB carry-in:
  - ADD: `cin`.
  - SUB/SLT: forced 1 (`cin` ignored).
  - Other opcodes: don't-care.
- Ripple chain: `add_1bit` slice i produces `sum[i]` and `c[i+1]`.
- Result selection:
  - ADD/SUB: `sum`.
  - XOR: `a ^ b`. Uses raw B, not `bin`.
  - SLT: bit0 = `sum[WIDTH-1] ^ ovf_raw`, other bits 0. This is a signed compare.
  - MUL: `a & b`.
  - Reserved: all zeros.
- `ovf_raw = c[WIDTH] ^ c[WIDTH-1]`.
- `cout` = `c[WIDTH]` for ADD/SUB/SLT, else 0. For SUB, `cout`=1 means no borrow.
- `ovf` = `ovf_raw` for ADD/SUB, else 0.
- `zero` is computed from the selected result.

## Timing
- Latency 1 cycle: inputs sampled at edge N, results visible after edge N.
- `in_valid`=1: `out`/`cout`/`ovf`/`zero` load and `out_valid`=1.
- `in_valid`=0: result registers hold their previous value and `out_valid`=0.
- Back-to-back valid inputs give a result every cycle; there is no backpressure.
- Reset (`rst_n`=0 at an edge):
  - `out`=0, `cout`=0, `ovf`=0, `zero`=0, `out_valid`=0.
  - Reset has priority over `in_valid`.
  - Reset mid-stream discards the operation being sampled that cycle.
- No combinational path from inputs to outputs.

## Configuration
- `ADD_MUX_SLICE_OVF_EN` defined: `ovf` is computed and registered as specified, and SLT uses the overflow correction.
- Not defined:
  - `ovf` port remains but is tied to 0 and its register is removed.
  - SLT bit0 = `sum[WIDTH-1]` (uncorrected). Results are valid only when A−B does not overflow.

## Structure
- Package `add_mux_pkg` holds the opcode localparams: `OP_ADD`, `OP_SUB`, `OP_XOR`, `OP_SLT`, `OP_MUL`.
- Sub-module `add_1bit` (ports: sum, cout, a, b, cin; purely combinational full adder) is instantiated WIDTH times in a generate loop.
- `mux_5bit` selection is implemented as a case on `cntrl` in the top level.

## Test plan
All cases use WIDTH=4.
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 and a=0111, b=0001 -> `out`=0000, `cout`=0, `ovf`=0, `zero`=0, `out_valid`=0.
- ADD:
  - a=0111, b=0001, cin=0 -> `out`=1000, `cout`=0, `ovf`=1.
  - Next cycle a=1111, b=0001, cin=0 -> `out`=0000, `cout`=1, `zero`=1.
  - a=0001, b=0001, cin=1 -> `out`=0011.
- SUB and SLT:
  - SUB a=0011, b=0101 -> `out`=1110, `cout`=0, `ovf`=0.
  - SLT on the same operands -> `out`=0001.
  - SLT a=0111, b=1000 -> `out`=0000; with the macro undefined -> 0001.
- Logic ops with a=1100, b=1010:
  - XOR -> 0110, `cout`=0.
  - MUL -> 1000.
  - Opcode 101 -> 0000, `zero`=1.
- Hold: after a valid ADD result 1000, drive `in_valid`=0 with new operands -> `out` stays 1000 and `out_valid`=0.
